// File: rtl/seg7_pkg.sv
// Shared seven-segment types, blank code and the active-high hex decode table.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h00;

  // Bit0 = a ... bit6 = g, 1 = segment lit.
  localparam seg7_t SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t hex2seg(input logic [3:0] nibble);
    return SEG7_LUT[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex2seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed seven-segment driver with frame-coherent shadow and anode dead time.
// Optional blinking of masked digits is built when SEG7_BLINK_EN is defined.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned DEAD_CYC     = 2,
  parameter bit          ACTIVE_LOW   = 1'b1
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    en_prev_q, en_prev_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  seg7_t                   seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick, wrap, capture, blank_slot;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  seg7_t                   cur_seg;

  always_comb begin
    tick      = en && (presc_q == PRESC_LAST);
    wrap      = tick && (idx_q == IDX_LAST);
    // Snapshot on frame wrap and on the first enabled cycle (en_prev_q is 0 after reset).
    capture   = en && (!en_prev_q || wrap);
    en_prev_d = en;
    presc_d   = '0;
    idx_d     = '0;
    if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if ((NUM_DIGITS > 1) && tick) begin
        idx_d = wrap ? '0 : idx_q + 1'b1;
      end
    end
    sh_dig_d = capture ? digits : sh_dig_q;
    sh_dp_d  = capture ? dp_in  : sh_dp_q;
  end

  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib       = sh_dig_q[4*i +: 4];
        cur_dp        = sh_dp_q[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_dec u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] sh_mask_q, sh_mask_d;

  always_comb begin
    fcnt_d    = fcnt_q;
    phase_d   = phase_q;
    sh_mask_d = capture ? blink_mask : sh_mask_q;
    if (wrap) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    blank_slot = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        blank_slot = !phase_q && sh_mask_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q    <= '0;
      phase_q   <= 1'b1;
      sh_mask_q <= '0;
    end else begin
      fcnt_q    <= fcnt_d;
      phase_q   <= phase_d;
      sh_mask_q <= sh_mask_d;
    end
  end
`else
  always_comb begin
    blank_slot = 1'b0;
  end
`endif

  always_comb begin
    seg_d = SEG7_BLANK;
    dp_d  = 1'b0;
    an_d  = '0;
    if (en) begin
      seg_d = cur_seg;
      dp_d  = cur_dp;
      if ((presc_q >= DEAD_LIM) && !blank_slot) begin
        an_d = sel_onehot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      en_prev_q <= 1'b0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      seg_q     <= SEG7_BLANK;
      dp_q      <= 1'b0;
      an_q      <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      en_prev_q <= en_prev_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  // Registers hold active-high values; polarity is applied only at the pins.
  assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp  = ACTIVE_LOW ? ~dp_q  : dp_q;
  assign an  = ACTIVE_LOW ? ~an_q  : an_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with NUM_DIGITS=4, CLK_DIV=8, DEAD_CYC=2, ACTIVE_LOW=1.
module tb_seg7_scan_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_drv #(
    .NUM_DIGITS (4),
    .CLK_DIV    (8),
    .DEAD_CYC   (2),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
`ifdef SEG7_BLINK_EN
    .blink_mask (4'b0000),
`endif
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  task automatic chk_an(input string tag, input logic [3:0] e_an);
    total++;
    assert (an === e_an) else begin
      bad++;
      $error("FAIL %s an=%h expected=%h", tag, an, e_an);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp);
    chk_an(tag, e_an);
    total++;
    assert (seg === e_seg) else begin
      bad++;
      $error("FAIL %s seg=%h expected=%h", tag, seg, e_seg);
    end
    total++;
    assert (dp === e_dp) else begin
      bad++;
      $error("FAIL %s dp=%b expected=%b", tag, dp, e_dp);
    end
  endtask

  // One 8-cycle digit slot: two dead cycles, then six with the digit shown.
  task automatic slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                      input logic e_dp);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 2) chk_an({tag, "_dead"}, 4'hF);
      else       chk(tag, e_an, e_seg, e_dp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset", 4'hF, 7'h7F, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_en0", 4'hF, 7'h7F, 1'b1);

    // Normal scan of 1234 with a mid-frame change that must stay invisible
    en = 1'b1; digits = 16'h1234; dp_in = 4'b0000;
    slot("f0_s0", 4'b1110, 7'h19, 1'b1);
    digits = 16'hFFFF;
    slot("f0_s1", 4'b1101, 7'h30, 1'b1);
    slot("f0_s2", 4'b1011, 7'h24, 1'b1);
    slot("f0_s3", 4'b0111, 7'h79, 1'b1);
    slot("f1_s0", 4'b1110, 7'h0E, 1'b1);
    slot("f1_s1", 4'b1101, 7'h0E, 1'b1);
    slot("f1_s2", 4'b1011, 7'h0E, 1'b1);
    slot("f1_s3", 4'b0111, 7'h0E, 1'b1);

    // Disable in the middle of slot 2
    slot("f2_s0", 4'b1110, 7'h0E, 1'b1);
    slot("f2_s1", 4'b1101, 7'h0E, 1'b1);
    repeat (2) begin @(negedge clk); chk_an("f2_s2_dead", 4'hF); end
    repeat (2) begin @(negedge clk); chk("f2_s2", 4'b1011, 7'h0E, 1'b1); end
    en = 1'b0;
    @(negedge clk); chk("disable_1", 4'hF, 7'h7F, 1'b1);
    @(negedge clk); chk("disable_2", 4'hF, 7'h7F, 1'b1);

    // Re-enable restarts at digit 0; then load 8888 with two decimal points
    en = 1'b1;
    slot("re_s0", 4'b1110, 7'h0E, 1'b1);
    digits = 16'h8888; dp_in = 4'b0101;
    slot("re_s1", 4'b1101, 7'h0E, 1'b1);
    slot("re_s2", 4'b1011, 7'h0E, 1'b1);
    slot("re_s3", 4'b0111, 7'h0E, 1'b1);
    slot("dp_s0", 4'b1110, 7'h00, 1'b0);
    slot("dp_s1", 4'b1101, 7'h00, 1'b1);
    slot("dp_s2", 4'b1011, 7'h00, 1'b0);
    slot("dp_s3", 4'b0111, 7'h00, 1'b1);

    // Asynchronous reset between clock edges in slot 3
    slot("ar_s0", 4'b1110, 7'h00, 1'b0);
    slot("ar_s1", 4'b1101, 7'h00, 1'b1);
    slot("ar_s2", 4'b1011, 7'h00, 1'b0);
    repeat (2) begin @(negedge clk); chk_an("ar_s3_dead", 4'hF); end
    repeat (2) begin @(negedge clk); chk("ar_s3", 4'b0111, 7'h00, 1'b1); end
    #2 rst_n = 1'b0;
    #1 chk("async_reset_now", 4'hF, 7'h7F, 1'b1);
    @(negedge clk); chk("async_reset_held", 4'hF, 7'h7F, 1'b1);
    rst_n = 1'b1;
    slot("rst_s0", 4'b1110, 7'h00, 1'b0);
    slot("rst_s1", 4'b1101, 7'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
- Parametrised multi-digit, time-multiplexed seven-segment display driver.
- Full hex decode (0-F) for all seven segments plus decimal point.
- Scans NUM_DIGITS digits one at a time, with a frame-coherent shadow snapshot and anode dead-time to suppress ghosting.
- Sits between game/score logic and the board's shared segment and anode pins.

Parameters:
- NUM_DIGITS, 4: digits scanned. Legal range 1..8.
- CLK_DIV, 50000: clk cycles per digit slot. Must be >= DEAD_CYC+2.
- DEAD_CYC, 2: cycles at the start of each slot with all anodes inactive.
- ACTIVE_LOW, 1: 1 = seg/dp/an asserted low; 0 = asserted high.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  display enable
- digits  input  4*NUM_DIGITS  hex nibbles; nibble i = digit i (digit 0 = rightmost)
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- seg  output  7  segments; bit0=a … bit6=g; polarity per ACTIVE_LOW
- dp  output  1  decimal point of the current digit
- an  output  NUM_DIGITS  one-hot digit select; polarity per ACTIVE_LOW

Behaviour:
- Clock and reset: single clock. rst_n is asynchronous and active-low.
- Reset values: prescaler=0, idx=0, shadow=0. Outputs inactive: seg all off (7'h7F when ACTIVE_LOW), dp off, an all off.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en=1, then wraps.
  - tick = en && (presc==CLK_DIV-1).
- Digit index:
  - idx advances on tick; wraps from NUM_DIGITS-1 to 0.
  - NUM_DIGITS=1: idx is constant 0.
- Shadow snapshot:
  - digits/dp_in are captured into shadow registers on frame wrap (tick && idx==NUM_DIGITS-1).
  - Also captured on the first enabled cycle after reset or after en rises.
  - Input changes mid-frame are invisible until the next wrap, so there is no tearing.
- Output register:
  - seg/dp/an are registered and reflect (idx, presc, shadow) from the previous cycle.
  - Net latency: one clk from a state change to the pins.
- Dead time:
  - an is all inactive while presc < DEAD_CYC.
  - Otherwise only bit idx of an is active.
  - seg/dp switch to the new digit on the first dead cycle.
- Decode, segments on:
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg
  - 4: bcfg; 5: acdfg; 6: acdefg; 7: abc
  - 8: abcdefg; 9: abcdfg; A: abcefg; b: cdefg
  - C: adef; d: bcdeg; E: adefg; F: aefg
- Polarity: ACTIVE_LOW inverts seg, dp and an uniformly at the output stage.
- en low:
  - Next clk: an all inactive, seg/dp off.
  - presc and idx clear to 0; shadow holds.
  - Re-enable restarts at digit 0 with dead time.
- Reset mid-scan: outputs go inactive immediately (asynchronous) and the scan restarts at digit 0.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- When defined:
  - Adds input port blink_mask [NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 64).
  - A blink phase flag toggles every BLINK_FRAMES completed frames; reset value is phase on.
  - During the off phase, digits whose mask bit is 1 have an held inactive for their slot.
  - blink_mask is snapshotted with the shadow registers.
- When undefined: no port, no phase logic, no blanking.

Decomposition:
- Package seg7_pkg:
  - typedef seg7_t (logic [6:0]).
  - localparam SEG7_BLANK.
  - constant 16-entry SEG7_LUT of seg7_t, active-high.
  - function hex2seg(nibble) returning seg7_t.
- Sub-module seg7_hex_dec: combinational nibble-to-active-high-segment decoder. Instanced once, on the shadow digit selected by idx.
- Top module keeps prescaler, idx, shadow, blink phase and the output register stage.

Test Plan (NUM_DIGITS=4, CLK_DIV=8, DEAD_CYC=2, ACTIVE_LOW=1):
- Reset: hold rst_n=0 → an=4'hF, seg=7'h7F, dp=1; release with en=0 → unchanged.
- Normal scan: en=1, digits=16'h1234, dp_in=0 → slot 0 shows seg=7'h19 (digit 4) with an=4'b1110 after 2 dead cycles. Slot 1 shows 7'h30 (digit 3), slot 2 shows 7'h24 (digit 2), slot 3 shows 7'h79 (digit 1). an is 4'hF for exactly 2 cycles per slot; one frame is 32 cycles.
- Mid-frame coherence: change digits to 16'hFFFF during slot 1 → slots 1-3 still show 3,2,1; next frame every slot shows seg=7'h0E.
- Disable/enable: drop en in slot 2 → next clk an=4'hF, seg=7'h7F; raise en → scan resumes at digit 0 after dead time.
- dp and all-on: digits=16'h8888, dp_in=4'b0101 → seg=7'h00 every slot; dp=0 on digits 0 and 2, dp=1 on digits 1 and 3.
- Async reset mid-scan: assert rst_n between clk edges in slot 3 → outputs inactive before the next edge; after release, the scan restarts at digit 0. With SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 → digit 0's anode is suppressed in frames 3-4 and restored in frames 5-6.
